// File: rtl/i2c_uart_pkg.sv
// Shared types and constants for the I2C-to-UART frame serialiser.
// The enum always carries ST_CHECK; it is only reachable when I2C_UART_CHECKSUM_EN is defined.
package i2c_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_MODE,
        ST_DATA1,
        ST_DATA2,
        ST_CHECK,
        ST_STOP
    } state_t;

    localparam logic [7:0] START_BYTE = 8'hFF;
    localparam logic [7:0] STOP_BYTE  = 8'hFF;
    localparam logic [7:0] IDLE_BYTE  = 8'h00;

    localparam logic [1:0] MODE_RD1 = 2'b00;
    localparam logic [1:0] MODE_RD2 = 2'b01;

    // Byte held by a state together with the state that follows it.
    typedef struct packed {
        logic [7:0] byte_val;
        state_t     nxt_state;
    } step_t;

endpackage

// File: rtl/i2c_to_uart_framer.sv
// Captures one I2C transaction record and streams it to the UART core as
// START, ADDR, MODE, [DATA1], [DATA2], STOP. Define I2C_UART_CHECKSUM_EN to add a CHECK byte before STOP.
module i2c_to_uart_framer #(
    parameter logic [7:0] START_BYTE = i2c_uart_pkg::START_BYTE,
    parameter logic [7:0] STOP_BYTE  = i2c_uart_pkg::STOP_BYTE,
    parameter logic [7:0] IDLE_BYTE  = i2c_uart_pkg::IDLE_BYTE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_ready,
    input  logic        tx_done_tick,
    input  logic [15:0] toPC_data,
    input  logic [7:0]  toPC_mode,
    input  logic [7:0]  toPC_address,
    output logic        tx_start,
    output logic [7:0]  data_byte,
    output logic        tx_complete
);
    import i2c_uart_pkg::*;

    state_t      state_q,   state_d;
    logic [7:0]  address_q, address_d;
    logic [7:0]  mode_q,    mode_d;
    logic [15:0] data_q,    data_d;

    step_t cur_step;
    step_t nxt_step;

    // Byte presented in state s and the state that follows it, for the captured record.
    function automatic step_t frame_step(input state_t      s,
                                         input logic [7:0]  addr,
                                         input logic [7:0]  mode,
                                         input logic [15:0] data);
        step_t  r;
        state_t tail;
        logic   has_d1;
        logic   has_d2;
`ifdef I2C_UART_CHECKSUM_EN
        logic [7:0] chk;
`endif
        has_d1 = (mode[1:0] == MODE_RD1) || (mode[1:0] == MODE_RD2);
        has_d2 = (mode[1:0] == MODE_RD2);
`ifdef I2C_UART_CHECKSUM_EN
        tail = ST_CHECK;
        chk  = addr ^ mode;
        if (has_d1) chk = chk ^ data[7:0];
        if (has_d2) chk = chk ^ data[15:8];
`else
        tail = ST_STOP;
`endif
        r.byte_val  = IDLE_BYTE;
        r.nxt_state = ST_IDLE;
        case (s)
            ST_IDLE:  r = '{byte_val: IDLE_BYTE,  nxt_state: ST_START};
            ST_START: r = '{byte_val: START_BYTE, nxt_state: ST_ADDR};
            ST_ADDR:  r = '{byte_val: addr,       nxt_state: ST_MODE};
            ST_MODE:  r = '{byte_val: mode,       nxt_state: has_d1 ? ST_DATA1 : tail};
            ST_DATA1: r = '{byte_val: data[7:0],  nxt_state: has_d2 ? ST_DATA2 : tail};
            ST_DATA2: r = '{byte_val: data[15:8], nxt_state: tail};
`ifdef I2C_UART_CHECKSUM_EN
            ST_CHECK: r = '{byte_val: chk,        nxt_state: ST_STOP};
`endif
            ST_STOP:  r = '{byte_val: STOP_BYTE,  nxt_state: ST_IDLE};
            default:  r = '{byte_val: IDLE_BYTE,  nxt_state: ST_IDLE};
        endcase
        return r;
    endfunction

    always_comb begin
        // NOTE: every output and _d signal gets a default first so no path infers a latch.
        cur_step    = frame_step(state_q, address_q, mode_q, data_q);
        nxt_step    = frame_step(cur_step.nxt_state, address_q, mode_q, data_q);
        state_d     = state_q;
        address_d   = address_q;
        mode_d      = mode_q;
        data_d      = data_q;
        tx_start    = 1'b1;
        data_byte   = cur_step.byte_val;
        tx_complete = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (data_ready) begin
                    tx_start  = 1'b0;
                    data_byte = nxt_step.byte_val;
                    address_d = toPC_address;
                    mode_d    = toPC_mode;
                    data_d    = toPC_data;
                    state_d   = ST_START;
                end
            end
            ST_STOP: begin
                // Last byte finished: report completion but launch nothing.
                if (tx_done_tick) begin
                    tx_complete = 1'b1;
                    data_byte   = IDLE_BYTE;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                if (tx_done_tick) begin
                    tx_start  = 1'b0;
                    data_byte = nxt_step.byte_val;
                    state_d   = cur_step.nxt_state;
                end
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments; reset is asynchronous so a mid-frame reset aborts at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            address_q <= '0;
            mode_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            address_q <= address_d;
            mode_q    <= mode_d;
            data_q    <= data_d;
        end
    end

endmodule

// File: tb/tb_i2c_to_uart_framer.sv
// Self-checking bench for i2c_to_uart_framer: directed frames plus randomised records and tick patterns
// checked against a byte-list model of the frame. Honours I2C_UART_CHECKSUM_EN.
module tb_i2c_to_uart_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        data_ready = 1'b0;
    logic        tx_done_tick = 1'b0;
    logic [15:0] toPC_data = '0;
    logic [7:0]  toPC_mode = '0;
    logic [7:0]  toPC_address = '0;
    logic        tx_start;
    logic [7:0]  data_byte;
    logic        tx_complete;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the whole frame as a byte list and the index of the byte the UART is sending.
    logic [7:0] frame_q[$];
    int         pos    = 0;
    bit         m_idle = 1'b1;

    always #5 clk = ~clk;

    i2c_to_uart_framer dut (
        .clk          (clk),
        .reset        (reset),
        .data_ready   (data_ready),
        .tx_done_tick (tx_done_tick),
        .toPC_data    (toPC_data),
        .toPC_mode    (toPC_mode),
        .toPC_address (toPC_address),
        .tx_start     (tx_start),
        .data_byte    (data_byte),
        .tx_complete  (tx_complete)
    );

    task automatic build_frame(input logic [7:0] a, input logic [7:0] m, input logic [15:0] d);
        logic [7:0] chk;
        frame_q = {};
        chk = a ^ m;
        frame_q.push_back(8'hFF);
        frame_q.push_back(a);
        frame_q.push_back(m);
        if (m[1:0] == 2'b00 || m[1:0] == 2'b01) begin
            frame_q.push_back(d[7:0]);
            chk = chk ^ d[7:0];
        end
        if (m[1:0] == 2'b01) begin
            frame_q.push_back(d[15:8]);
            chk = chk ^ d[15:8];
        end
`ifdef I2C_UART_CHECKSUM_EN
        frame_q.push_back(chk);
`endif
        frame_q.push_back(8'hFF);
    endtask

    // One clock: drive inputs, predict {tx_start, data_byte, tx_complete}, sample at negedge, advance model.
    task automatic step(input bit dr, input bit tick, output logic [9:0] exp_v, output logic [9:0] obs_v);
        data_ready   = dr;
        tx_done_tick = tick;
        if (m_idle)
            exp_v = dr ? {1'b0, 8'hFF, 1'b0} : {1'b1, 8'h00, 1'b0};
        else if (!tick)
            exp_v = {1'b1, frame_q[pos], 1'b0};
        else if (pos < frame_q.size() - 1)
            exp_v = {1'b0, frame_q[pos+1], 1'b0};
        else
            exp_v = {1'b1, 8'h00, 1'b1};
        @(negedge clk);
        obs_v = {tx_start, data_byte, tx_complete};
        @(posedge clk);
        #1;
        if (m_idle) begin
            if (dr) begin
                build_frame(toPC_address, toPC_mode, toPC_data);
                pos    = 0;
                m_idle = 1'b0;
            end
        end else if (tick) begin
            if (pos < frame_q.size() - 1) pos++;
            else m_idle = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [9:0] e, o;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({tx_start, data_byte, tx_complete} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_out: got %b/%h/%b want 1/00/0", tx_start, data_byte, tx_complete);
        end
        n_cmp++;
        if ({dut.address_q, dut.mode_q, dut.data_q} !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_regs: got %h/%h/%h want 00/00/0000", dut.address_q, dut.mode_q, dut.data_q);
        end
        reset  = 1'b0;
        m_idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0], e, o);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL idle_hold c%0d: got %b/%h/%b want %b/%h/%b", i, o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
            end
        end
    endtask

    // Run the current frame out with a tick probability of pct percent; bounded.
    task automatic drain(input string tag, input int pct);
        logic [9:0] e, o;
        int n;
        n = 0;
        while (!m_idle && n < 200) begin
            step(1'b0, ($urandom_range(99) < pct), e, o);
            n++;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL %s c%0d: got %b/%h/%b want %b/%h/%b", tag, n, o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
            end
        end
        if (!m_idle) begin
            n_fail++;
            $display("FAIL %s_timeout: frame still open after %0d cycles, want idle", tag, n);
            m_idle = 1'b1;
        end
    endtask

    task automatic test_read2();
        logic [9:0] e, o;
        logic [7:0] seen[$];
        logic [7:0] want[$];
        bit         cmp_seen[$];
        int         n;
        want = '{8'hFF, 8'h48, 8'h01, 8'hEF, 8'hBE,
`ifdef I2C_UART_CHECKSUM_EN
                 8'h18,
`endif
                 8'hFF, 8'h00};
        toPC_address = 8'h48;
        toPC_mode    = 8'h01;
        toPC_data    = 16'hBEEF;
        n = 0;
        step(1'b1, 1'b1, e, o);
        seen.push_back(o[8:1]);
        cmp_seen.push_back(o[0]);
        while (!m_idle && n < 20) begin
            step(1'b0, 1'b1, e, o);
            seen.push_back(o[8:1]);
            cmp_seen.push_back(o[0]);
            n++;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL read2 c%0d: got %b/%h/%b want %b/%h/%b", n, o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
            end
        end
        n_cmp++;
        if (seen.size() != want.size()) begin
            n_fail++;
            $display("FAIL read2_len: got %0d bytes want %0d", seen.size(), want.size());
        end else begin
            for (int i = 0; i < want.size(); i++) begin
                n_cmp++;
                if (seen[i] !== want[i] || cmp_seen[i] !== (i == want.size() - 1)) begin
                    n_fail++;
                    $display("FAIL read2_seq[%0d]: got %h/%b want %h/%b", i, seen[i], cmp_seen[i], want[i], (i == want.size() - 1));
                end
            end
        end
    endtask

    task automatic test_read1_write();
        logic [9:0] e, o;
        bit saw_12;
        saw_12 = 1'b0;
        toPC_address = 8'h3C;
        toPC_mode    = 8'h00;
        toPC_data    = 16'h1234;
        step(1'b1, 1'b0, e, o);
        while (!m_idle) begin
            step(1'b0, 1'b1, e, o);
            if (o[8:1] == 8'h12) saw_12 = 1'b1;
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL read1: got %b/%h/%b want %b/%h/%b", o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
            end
        end
        n_cmp++;
        if (saw_12) begin
            n_fail++;
            $display("FAIL read1_hi_byte: got byte 12 on the wire, want it never sent");
        end
        toPC_address = 8'h77;
        toPC_mode    = 8'h02;
        step(1'b1, 1'b0, e, o);
        drain("write", 100);
    endtask

    task automatic test_stall();
        logic [9:0] e, o;
        toPC_address = 8'h5A;
        toPC_mode    = 8'h03;
        toPC_data    = 16'hA5C3;
        step(1'b1, 1'b0, e, o);
        step(1'b0, 1'b1, e, o);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, (i == 5), e, o);
            n_cmp++;
            if (o !== e || (i < 5 && o !== {1'b1, 8'h5A, 1'b0}) || (i == 5 && o !== {1'b0, 8'h03, 1'b0})) begin
                n_fail++;
                $display("FAIL stall c%0d: got %b/%h/%b want %b/%h/%b", i, o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
            end
        end
        drain("stall_tail", 100);
    endtask

    task automatic test_reset_mid();
        logic [9:0] e, o;
        toPC_address = 8'h21;
        toPC_mode    = 8'h01;
        toPC_data    = 16'h6655;
        step(1'b1, 1'b0, e, o);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, e, o);
        tx_done_tick = 1'b0;
        data_ready   = 1'b0;
        reset = 1'b1;
        #2;
        n_cmp++;
        if ({tx_start, data_byte, tx_complete} !== {1'b1, 8'h00, 1'b0} || dut.data_q !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got %b/%h/%b data_q=%h want 1/00/0 data_q=0000", tx_start, data_byte, tx_complete, dut.data_q);
        end
        #1;
        reset  = 1'b0;
        m_idle = 1'b1;
        @(posedge clk);
        #1;
        toPC_address = 8'h19;
        toPC_mode    = 8'h00;
        step(1'b1, 1'b0, e, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_restart: got %b/%h/%b want %b/%h/%b", o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
        end
        drain("reset_restart", 70);
    endtask

    // data_ready held through the STOP exit cycle must not start a frame until the next IDLE cycle.
    task automatic test_back_to_back();
        logic [9:0] e, o;
        toPC_address = 8'h40;
        toPC_mode    = 8'h02;
        step(1'b1, 1'b0, e, o);
        while (!m_idle) begin
            step(1'b1, 1'b1, e, o);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b: got %b/%h/%b want %b/%h/%b", o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
            end
        end
        toPC_address = 8'h41;
        toPC_mode    = 8'h00;
        step(1'b1, 1'b1, e, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL b2b_second: got %b/%h/%b want %b/%h/%b", o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
        end
        drain("b2b_second", 100);
    endtask

    task automatic test_random();
        logic [9:0] e, o;
        int n;
        for (int f = 0; f < 40; f++) begin
            n = 0;
            while (m_idle && n < 50) begin
                toPC_address = 8'($urandom);
                toPC_mode    = 8'($urandom);
                toPC_data    = 16'($urandom);
                step(($urandom_range(3) == 0), 1'($urandom), e, o);
                n++;
                n_cmp++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rand_idle f%0d: got %b/%h/%b want %b/%h/%b", f, o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
                end
            end
            n = 0;
            while (!m_idle && n < 200) begin
                toPC_address = 8'($urandom);
                toPC_mode    = 8'($urandom);
                toPC_data    = 16'($urandom);
                step(1'($urandom), ($urandom_range(99) < 50), e, o);
                n++;
                n_cmp++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL rand f%0d c%0d: got %b/%h/%b want %b/%h/%b", f, n, o[9], o[8:1], o[0], e[9], e[8:1], e[0]);
                end
            end
            if (!m_idle) begin
                n_fail++;
                $display("FAIL rand_timeout f%0d: frame still open, want idle", f);
                m_idle = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_read2();
        test_read1_write();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
